core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits inside the core top, between the fetch/LSU stages and the external memory bus.
- Allows one outstanding transaction at a time, with round-robin arbitration on contention.
- Has a response-timeout watchdog so a hung memory cannot stall the pipeline forever.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8)
- TIMEOUT, 255, maximum cycles spent waiting for mem_rvalid before an error response (must be ≥1)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted by memory
- if_rvalid  out  1  fetch response valid (1 cycle)
- if_rdata  out  DW  fetch read data
- if_err  out  1  fetch response is a timeout error (qualified by if_rvalid)
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = write
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  data response / write ack (1 cycle)
- d_rdata  out  DW  load data
- d_err  out  1  data response is a timeout error
- mem_req  out  1  memory request
- mem_we  out  1  write
- mem_be  out  DW/8  byte enables
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response; also the acknowledge for writes
- mem_rdata  in  DW  memory read data
- timeout_err  out  1  sticky flag: some timeout has occurred; cleared only by rst

Behaviour:
- States: IDLE and WAIT. Reset state is IDLE, with last_owner=IF so D wins the first contention.
- Reset values of outputs: all *_gnt, *_rvalid, *_err, mem_req and timeout_err = 0; rdata outputs = 0.
- IDLE, selection:
  - Only one requester active: select it.
  - Both active: select the requester that is not last_owner.
- IDLE, memory drive:
  - mem_req = if_req | d_req, combinational (zero-cycle issue).
  - The mem_* payload is muxed from the selected requester.
  - For an IF selection: mem_we=0, mem_be=all ones, mem_wdata=0.
- Grant: x_gnt = selected_x & mem_gnt.
- On grant:
  - Register owner, and set last_owner=owner.
  - Clear the wait counter to 0.
  - Go to WAIT.
- While mem_gnt=0: the selection must stay stable. If the unselected requester raises req later, the current selection is kept until granted; no switching mid-handshake.
- WAIT:
  - mem_req=0. Any mem_gnt is ignored.
  - Counter increments each cycle.
  - On mem_rvalid=1: owner's x_rvalid=1 and x_rdata=mem_rdata (combinational pass-through), x_err=0; next state IDLE.
  - On counter==TIMEOUT-1 with no mem_rvalid: owner's x_rvalid=1, x_err=1, x_rdata=0; set timeout_err; next state IDLE.
  - If mem_rvalid and the timeout coincide, mem_rvalid wins (normal response, no error).
- In IDLE, mem_rvalid is ignored. This discards late responses that arrive after a timeout.
- Non-owner rvalid/err are always 0. rdata of the non-owner = 0.
- No new request is issued in the response cycle. Minimum spacing is 2 cycles between back-to-back transactions (grant, response).
- Counter is clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- rst asserted mid-WAIT:
  - Return to IDLE next cycle; outputs go to reset values; the outstanding response is dropped.
  - Requesters are reset by the same rst.

Decomposition:
- Shared core package/header: owner encoding constants (OWN_IF=0, OWN_D=1), state encoding (ST_IDLE, ST_WAIT), and the default TIMEOUT.
- One natural sub-module: core_rr_pick2, a 2-way round-robin selector. Inputs are req[1:0], last_owner and a hold flag; output is a one-hot select. The remaining logic (FSM, payload mux, timeout counter) stays in core_mem_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with both reqs high → all gnt/rvalid/mem_req=0. After release, first contention grants D.
- Single IF read: if_req, addr=0x100, mem_gnt=1, mem_rvalid 3 cycles later with rdata=0xDEADBEEF → if_gnt in cycle 0, if_rvalid=1 and if_rdata=0xDEADBEEF in cycle 3, d_* quiet.
- Contention with round-robin: both reqs held for 4 transactions, mem responds in 1 cycle → grant order D, IF, D, IF, each grant ≥2 cycles apart.
- Backpressure: d_req with mem_gnt=0 for 5 cycles, if_req rising at cycle 2 → mem_addr stays at d_addr throughout; d_gnt when mem_gnt=1; IF granted next.
- Timeout: TIMEOUT=8, D write granted, no mem_rvalid → d_rvalid=1 and d_err=1 exactly 8 cycles after grant; timeout_err stays 1; a late mem_rvalid at cycle 10 is ignored.
- Tie and mid-transaction reset: mem_rvalid on the same cycle as the timeout → err=0 with data passed through. In a separate run, rst in WAIT → IDLE next cycle and no rvalid is produced.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// Shared constants for the core memory-port arbiter.
// Owner encoding, FSM state encoding and the default response timeout.
package core_mem_arbiter_pkg;

   // Owner encoding; also the bit index in the one-hot select
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/core_mem_arbiter_rr.sv
// core_rr_pick2: 2-way round-robin selector with selection hold.
// Ports: req[1:0] (bit0=IF, bit1=D), last_owner, hold -> one-hot sel.
module core_rr_pick2
   import core_mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       last_owner,
   input  logic       hold,
   output logic [1:0] sel
);

   logic [1:0] sel_q;
   logic [1:0] sel_d;
   logic [1:0] rr_sel;

   always_comb begin
      rr_sel = req;
      if (req == 2'b11) begin
         rr_sel = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
      end
      sel_d = rr_sel;
      // Keep last cycle's pick while the bus handshake is stalled
      if (hold && (|(sel_q & req))) begin
         sel_d = sel_q;
      end
   end

   assign sel = sel_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= '0;
      end else begin
         sel_q <= sel_d;
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (D).
// Ports: if_* and d_* requesters, mem_* bus, sticky timeout_err.
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   output logic            if_err,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_be,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            d_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [DW/8-1:0] mem_be,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata,
   output logic            timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [0:0]    state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          hold_q, hold_d;
   logic          terr_q, terr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [1:0] sel;
   logic       idle;
   logic       any_req;
   logic       tmo;
   logic       rsp_ok;
   logic       rsp_to;
   logic       rv;

   core_rr_pick2 u_pick (
      .clk        (clk),
      .rst        (rst),
      .req        ({d_req, if_req}),
      .last_owner (last_q),
      .hold       (hold_q),
      .sel        (sel)
   );

   assign idle    = (state_q == ST_IDLE);
   assign any_req = if_req | d_req;
   assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
   // A response on the timeout cycle still counts as a normal response
   assign rsp_ok  = !idle & mem_rvalid;
   assign rsp_to  = !idle & !mem_rvalid & tmo;
   assign rv      = !rst & (rsp_ok | rsp_to);

   assign mem_req   = !rst & idle & any_req;
   assign mem_we    = sel[OWN_D] & d_we;
   assign mem_be    = sel[OWN_D] ? d_be : '1;
   assign mem_addr  = sel[OWN_D] ? d_addr : if_addr;
   assign mem_wdata = sel[OWN_D] ? d_wdata : '0;

   assign if_gnt = !rst & idle & sel[OWN_IF] & mem_gnt;
   assign d_gnt  = !rst & idle & sel[OWN_D] & mem_gnt;

   assign if_rvalid = rv & (owner_q == OWN_IF);
   assign d_rvalid  = rv & (owner_q == OWN_D);
   assign if_err    = if_rvalid & rsp_to;
   assign d_err     = d_rvalid & rsp_to;
   assign if_rdata  = (if_rvalid & rsp_ok) ? mem_rdata : '0;
   assign d_rdata   = (d_rvalid & rsp_ok) ? mem_rdata : '0;

   assign timeout_err = terr_q;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      hold_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            hold_d = any_req & !mem_gnt;
            if (any_req && mem_gnt) begin
               owner_d = sel[OWN_D] ? OWN_D : OWN_IF;
               last_d  = owner_d;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (mem_rvalid) begin
               state_d = ST_IDLE;
            end else if (tmo) begin
               state_d = ST_IDLE;
               terr_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         last_q  <= OWN_IF;
         hold_q  <= 1'b0;
         terr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         terr_q  <= terr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter (TIMEOUT=8).
// Inputs driven 1ns after posedge, outputs checked 2ns after posedge.
module tb_core_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        timeout_err;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   core_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      if_req = 0; d_req = 0; d_we = 0; d_be = 4'hf;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
   endtask

   logic [3:0] ord = 4'b0101;

   initial begin
      quiet();
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      // Reset with both requesters active
      rst = 1; if_req = 1; d_req = 1; mem_gnt = 1;
      if_addr = 32'h1000; d_addr = 32'h2000;
      step();
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
      check("rst_terr", timeout_err, 0);
      step();
      check("rst2_gnt", {if_gnt, d_gnt, mem_req}, 0);
      rst = 0;
      // Round robin under contention, 1-cycle memory
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = 0;
         #1;
         check("rr_gnt_d", d_gnt, ord[k]);
         check("rr_gnt_if", if_gnt, !ord[k]);
         check("rr_addr", mem_addr, ord[k] ? 32'h2000 : 32'h1000);
         step();
         mem_rvalid = 1; mem_rdata = 32'(k + 1);
         #1;
         check("rr_rvalid", ord[k] ? d_rvalid : if_rvalid, 1);
         check("rr_other", ord[k] ? if_rvalid : d_rvalid, 0);
         check("rr_rdata", ord[k] ? d_rdata : if_rdata, k + 1);
         check("rr_gap", {if_gnt, d_gnt, mem_req}, 0);
         step();
      end
      quiet();
      // Single IF read, response 3 cycles after grant
      if_req = 1; if_addr = 32'h100; mem_gnt = 1;
      #1;
      check("ifr_gnt", if_gnt, 1);
      check("ifr_dgnt", d_gnt, 0);
      check("ifr_addr", mem_addr, 32'h100);
      check("ifr_we_be", {mem_we, mem_be}, 5'h0f);
      check("ifr_wdata", mem_wdata, 0);
      step(); quiet(); #1;
      check("ifr_wait1", if_rvalid, 0);
      step(); #1;
      check("ifr_wait2", if_rvalid, 0);
      step(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
      check("ifr_rvalid", if_rvalid, 1);
      check("ifr_rdata", if_rdata, 32'hDEADBEEF);
      check("ifr_err", if_err, 0);
      check("ifr_d_quiet", {d_rvalid, d_err, d_rdata}, 0);
      step(); quiet();
      // D write payload
      d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h204;
      d_wdata = 32'hCAFE; mem_gnt = 1;
      #1;
      check("dw_gnt", d_gnt, 1);
      check("dw_we_be", {mem_we, mem_be}, 5'h13);
      check("dw_wdata", mem_wdata, 32'hCAFE);
      check("dw_addr", mem_addr, 32'h204);
      step(); quiet(); mem_rvalid = 1; #1;
      check("dw_ack", {d_rvalid, d_err}, 2'b10);
      step(); quiet();
      // Backpressure: D stalled, IF arrives, D must stay selected
      d_req = 1; d_addr = 32'h200; if_addr = 32'h300;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) if_req = 1;
         #1;
         check("bp_addr", mem_addr, 32'h200);
         check("bp_req_gnt", {mem_req, if_gnt, d_gnt}, 3'b100);
         step();
      end
      mem_gnt = 1; #1;
      check("bp_dgnt", {if_gnt, d_gnt}, 2'b01);
      check("bp_addr_g", mem_addr, 32'h200);
      step(); d_req = 0; mem_rvalid = 1; #1;
      check("bp_drv", d_rvalid, 1);
      step(); mem_rvalid = 0; #1;
      check("bp_ifgnt", {if_gnt, d_gnt}, 2'b10);
      check("bp_ifaddr", mem_addr, 32'h300);
      step(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h77; #1;
      check("bp_ifrv", if_rdata, 32'h77);
      step(); quiet();
      // Timeout on a D write
      d_req = 1; d_we = 1; d_addr = 32'h400; mem_gnt = 1;
      #1;
      check("to_gnt", d_gnt, 1);
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 1) quiet();
         #1;
         check("to_wait", d_rvalid, 0);
      end
      step(); #1;
      check("to_rvalid", d_rvalid, 1);
      check("to_err", d_err, 1);
      check("to_rdata", d_rdata, 0);
      check("to_if_quiet", {if_rvalid, if_err}, 0);
      step(); #1;
      check("to_sticky", timeout_err, 1);
      check("to_once", d_rvalid, 0);
      step(); mem_rvalid = 1; mem_rdata = 32'h55; #1;
      check("to_late", {if_rvalid, d_rvalid}, 0);
      check("to_sticky2", timeout_err, 1);
      step(); quiet();
      // Response on the timeout cycle wins
      if_req = 1; if_addr = 32'h600; mem_gnt = 1;
      #1;
      check("tie_gnt", if_gnt, 1);
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 1) quiet();
      end
      step(); mem_rvalid = 1; mem_rdata = 32'h12345678; #1;
      check("tie_rvalid", if_rvalid, 1);
      check("tie_err", if_err, 0);
      check("tie_rdata", if_rdata, 32'h12345678);
      step(); quiet();
      // Reset while waiting for a response
      d_req = 1; d_addr = 32'h500; mem_gnt = 1;
      #1;
      check("mr_gnt", d_gnt, 1);
      step(); quiet(); #1;
      step(); rst = 1; mem_rvalid = 1; mem_rdata = 32'h99; #1;
      check("mr_in_rst", {d_rvalid, if_rvalid, mem_req}, 0);
      step(); rst = 0; #1;
      check("mr_dropped", {d_rvalid, if_rvalid}, 0);
      check("mr_terr_clr", timeout_err, 0);
      mem_rvalid = 0; if_req = 1; d_req = 1; mem_gnt = 1;
      if_addr = 32'h700; d_addr = 32'h800;
      #1;
      check("mr_first_d", {if_gnt, d_gnt}, 2'b01);
      step(); quiet(); mem_rvalid = 1; #1;
      check("mr_d_rv", d_rvalid, 1);
      step(); quiet();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
